// File: rtl/ecg_sample_normalizer.sv
// ECG sample normalizer: takes a signed sample, splits it into sign and
// magnitude, then scans the magnitude one nibble per cycle from the top to
// find the leading-zero count and left-justify the mantissa.
module ecg_sample_normalizer #(
  parameter  int unsigned NIB = 4,
  localparam int unsigned DW  = 4 * NIB,
  localparam int unsigned EW  = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [DW-1:0] out_mant,
  output logic [EW-1:0] out_exp
);

  localparam int unsigned NW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic          sign_q, sign_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [NW-1:0] nib_q, nib_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;

  logic [3:0]    scan_nib;
  logic          scan_hit;
  logic [EW-1:0] scan_exp;
  logic [DW-1:0] scan_mant;

  // Leading-zero count of a single nibble (0000 -> 4).
  function automatic logic [2:0] lz4(input logic [3:0] n);
    if (n[3])      return 3'd0;
    else if (n[2]) return 3'd1;
    else if (n[1]) return 3'd2;
    else if (n[0]) return 3'd3;
    else           return 3'd4;
  endfunction

  // Nibble under examination and the result it would produce if it terminates the scan.
  always_comb begin
    scan_nib  = mag_q[4*nib_q +: 4];
    scan_hit  = (scan_nib != 4'd0) || (nib_q == '0);
    scan_exp  = EW'(4 * (NIB - 1 - 32'(nib_q))) + EW'(lz4(scan_nib));
    // An all-zero magnitude ends with exp == DW; the mantissa is then zero.
    scan_mant = (scan_exp == EW'(DW)) ? '0 : (mag_q << scan_exp);
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      nib_q   <= NW'(NIB - 1);
      valid_q <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      nib_q   <= nib_d;
      valid_q <= valid_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StScan;
      StScan:  if (scan_hit)  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: capture on accept, step the nibble index, publish the result.
  always_comb begin
    sign_d  = sign_q;
    mag_d   = mag_q;
    nib_d   = nib_q;
    valid_d = valid_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = in_data[DW-1];
          // Most negative value wraps to 1000...0, which is the correct magnitude.
          mag_d  = in_data[DW-1] ? ((~in_data) + DW'(1)) : in_data;
          nib_d  = NW'(NIB - 1);
        end
      end
      StScan: begin
        if (scan_hit) begin
          exp_d   = scan_exp;
          mant_d  = scan_mant;
          valid_d = 1'b1;
        end else begin
          nib_d = nib_q - NW'(1);
        end
      end
      StDone: begin
        if (out_ready) valid_d = 1'b0;
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = valid_q;
    out_sign  = sign_q;
    out_mant  = mant_q;
    out_exp   = exp_q;
  end

endmodule

// File: tb/tb_ecg_sample_normalizer.sv
// Self-checking bench for ecg_sample_normalizer (NIB=4) against a
// transaction-level reference model.
module tb_ecg_sample_normalizer;

  localparam int NIB = 4;
  localparam int DW  = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data  = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [DW-1:0] out_mant;
  logic [4:0]    out_exp;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  ecg_sample_normalizer #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mant  (out_mant),
    .out_exp   (out_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [15:0] mant;
    logic [4:0]  exp;
    int          s;
  } res_t;

  // Reference: sign/magnitude, leading-zero count by bit search, latency from exponent.
  function automatic res_t ref_norm(input logic [15:0] d);
    res_t r;
    logic [15:0] mag;
    r.sign = d[15];
    mag    = d[15] ? (16'h0 - d) : d;
    r.exp  = 5'd16;
    for (int i = 0; i < 16; i++) if (mag[i]) r.exp = 5'(15 - i);
    r.mant = (r.exp == 5'd16) ? 16'h0 : (mag << r.exp);
    r.s    = (r.exp == 5'd16) ? NIB : (int'(r.exp) / 4 + 1);
    return r;
  endfunction

  function automatic int ref_lat(input logic [15:0] d);
    res_t r;
    r = ref_norm(d);
    return r.s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model: ready/busy-for-s-cycles/holding-result.
  logic m_ready, m_valid;
  int   m_wait;
  res_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_res   <= ref_norm(in_data);
        m_wait  <= ref_lat(in_data);
        m_ready <= 1'b0;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_sign", 32'(out_sign), 32'(m_res.sign));
        chk("out_mant", 32'(out_mant), 32'(m_res.mant));
        chk("out_exp", 32'(out_exp), 32'(m_res.exp));
      end
    end
  end

  // One transaction: accept d, scramble inputs during the scan, stall the result for hold cycles.
  task automatic xfer(input logic [15:0] d, input int hold, input logic lit,
                      input logic l_sign, input logic [4:0] l_exp, input logic [15:0] l_mant,
                      input int l_lat);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'($urandom);
    @(posedge clk);
    #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(ref_lat(d)));
    if (lit) begin
      chk("lit_latency", 32'(lat), 32'(l_lat));
      chk("lit_sign", 32'(out_sign), 32'(l_sign));
      chk("lit_exp", 32'(out_exp), 32'(l_exp));
      chk("lit_mant", 32'(out_mant), 32'(l_mant));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    int   seen;

    // Pin the reference model with hand-computed values.
    r = ref_norm(16'h4000);
    chk("ref_4000_exp", 32'(r.exp), 32'd1);
    chk("ref_4000_mant", 32'(r.mant), 32'h8000);
    r = ref_norm(16'hF9C0);
    chk("ref_f9c0_exp", 32'(r.exp), 32'd5);
    chk("ref_f9c0_mant", 32'(r.mant), 32'hC800);
    r = ref_norm(16'h0000);
    chk("ref_0000_lat", 32'(r.s), 32'd4);

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sign", 32'(out_sign), 32'd0);
    chk("rst_out_mant", 32'(out_mant), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed vectors with literal expectations.
    xfer(16'h4000, 0, 1'b1, 1'b0, 5'd1,  16'h8000, 1);
    xfer(16'h0001, 0, 1'b1, 1'b0, 5'd15, 16'h8000, 4);
    xfer(16'h0000, 0, 1'b1, 1'b0, 5'd16, 16'h0000, 4);
    xfer(16'hFFFF, 1, 1'b1, 1'b1, 5'd15, 16'h8000, 4);
    xfer(16'h8000, 2, 1'b1, 1'b1, 5'd0,  16'h8000, 1);
    xfer(16'hF9C0, 0, 1'b1, 1'b1, 5'd5,  16'hC800, 2);
    xfer(16'h00A3, 5, 1'b1, 1'b0, 5'd8,  16'hA300, 3);

    // Reset during the second scan cycle discards the sample.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_rst_valid", 32'(out_valid), 32'd0);
    chk("midscan_rst_mant", 32'(out_mant), 32'd0);
    chk("midscan_rst_exp", 32'(out_exp), 32'd0);
    chk("midscan_rst_sign", 32'(out_sign), 32'd0);
    chk("midscan_rst_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("no_result_after_rst", 32'(seen), 32'd0);

    // Top-nibble sweep.
    for (int x = 0; x < 16; x++) xfer(16'(x << 12), 0, 1'b0, 1'b0, 5'd0, 16'h0, 0);

    // Random signed samples with random stalls; vary the magnitude range.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      d = d >>> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) d = 16'h0 - d;
      xfer(d, $urandom_range(0, 3), 1'b0, 1'b0, 5'd0, 16'h0, 0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
